// File: rtl/mdu.sv
// Iterative multiply/divide unit with HI/LO registers: shift-add multiply and
// restoring divide, one bit per cycle, sign fix-up in a single final cycle.
`timescale 1ns/1ps
module mdu #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         clr,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    localparam int unsigned CW = $clog2(W + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;
    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_e;

    state_e          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_div;
    logic            r_bzero;
    logic            r_neg_lo;
    logic            r_neg_hi;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_m;
    logic [2*W-1:0]  r_acc;
    logic            r_busy;
    logic            r_done;
    logic [W-1:0]    r_hi;
    logic [W-1:0]    r_lo;

    logic            w_signed;
    logic            w_is_div;
    logic            w_is_arith;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [W-1:0]    w_a_mag;
    logic [W-1:0]    w_b_mag;
    logic [W:0]      w_madd;
    logic [W:0]      w_shift;
    logic [W:0]      w_dsub;
    logic            w_ge;
    logic [W-1:0]    w_drem;
    logic [2*W-1:0]  w_mul_next;
    logic [2*W-1:0]  w_div_next;
    logic [2*W-1:0]  w_prod;
    logic [W-1:0]    w_quo;
    logic [W-1:0]    w_rem;

    assign w_signed   = (op == OP_MULT) || (op == OP_DIV);
    assign w_is_div   = (op == OP_DIV)  || (op == OP_DIVU);
    assign w_is_arith = (op == OP_MULT) || (op == OP_MULTU) || w_is_div;
    assign w_a_neg    = w_signed & a[W-1];
    assign w_b_neg    = w_signed & b[W-1];
    assign w_a_mag    = w_a_neg ? -a : a;
    assign w_b_mag    = w_b_neg ? -b : b;

    // r_acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    assign w_madd     = {1'b0, r_acc[2*W-1:W]} + ({(W+1){r_acc[0]}} & {1'b0, r_m});
    assign w_mul_next = {w_madd, r_acc[W-1:1]};
    assign w_shift    = {r_acc[2*W-1:W], r_acc[W-1]};
    assign w_dsub     = w_shift - {1'b0, r_m};
    assign w_ge       = (w_shift >= {1'b0, r_m});
    assign w_drem     = w_ge ? w_dsub[W-1:0] : w_shift[W-1:0];
    assign w_div_next = {w_drem, r_acc[W-2:0], w_ge};

    assign w_prod     = r_neg_lo ? -r_acc : r_acc;
    assign w_quo      = r_neg_lo ? -r_acc[W-1:0] : r_acc[W-1:0];
    assign w_rem      = r_neg_hi ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_div    <= 1'b0;
            r_bzero  <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_a      <= '0;
            r_m      <= '0;
            r_acc    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !clr) begin
                        if (w_is_arith) begin
                            r_div    <= w_is_div;
                            r_a      <= a;
                            r_m      <= w_b_mag;
                            r_acc    <= {{W{1'b0}}, w_a_mag};
                            r_bzero  <= (b == '0);
                            r_neg_lo <= w_a_neg ^ w_b_neg;
                            r_neg_hi <= w_a_neg;
                            r_cnt    <= CW'(W);
                            r_busy   <= 1'b1;
                            r_state  <= S_RUN;
                        end else if (op == OP_MTHI) begin
                            r_hi <= a;
                        end else if (op == OP_MTLO) begin
                            r_lo <= a;
                        end
                    end
                end
                S_RUN: begin
                    if (clr) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= r_div ? w_div_next : w_mul_next;
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == CW'(1)) begin
                            r_state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (!clr) begin
                        if (!r_div) begin
                            r_hi <= w_prod[2*W-1:W];
                            r_lo <= w_prod[W-1:0];
                        end else if (r_bzero) begin
                            r_hi <= r_a;
                            r_lo <= '1;
                        end else begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end
                        r_done <= 1'b1;
                    end
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed literal cases plus randomized traffic
// checked every cycle against a latency-level arithmetic model.
`timescale 1ns/1ps
module tb_mdu;

    localparam int unsigned W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [2:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          clr;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int n_tests = 0;
    int n_fail  = 0;

    mdu #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .clr   (clr),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    // Architectural result of one MULT/MULTU/DIV/DIVU request.
    function automatic void calc(input logic [2:0] xop, input logic [31:0] xa,
                                 input logic [31:0] xb,
                                 output logic [31:0] h, output logic [31:0] l);
        longint      sa, sb, p;
        logic [63:0] pu;
        int          ia, ib;
        h = '0;
        l = '0;
        case (xop)
            3'd0: begin
                sa = longint'($signed(xa));
                sb = longint'($signed(xb));
                p  = sa * sb;
                pu = p;
                h  = pu[63:32];
                l  = pu[31:0];
            end
            3'd1: begin
                pu = {32'b0, xa} * {32'b0, xb};
                h  = pu[63:32];
                l  = pu[31:0];
            end
            3'd2: begin
                if (xb == 0) begin
                    h = xa; l = '1;
                end else if (xa == 32'h8000_0000 && xb == 32'hFFFF_FFFF) begin
                    h = '0; l = xa;
                end else begin
                    ia = xa; ib = xb;
                    l = ia / ib;
                    h = ia % ib;
                end
            end
            3'd3: begin
                if (xb == 0) begin
                    h = xa; l = '1;
                end else begin
                    l = xa / xb;
                    h = xa % xb;
                end
            end
            default: ;
        endcase
    endfunction

    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] p_hi = '0;
    logic [31:0] p_lo = '0;
    int          m_left = 0;

    // Model: an accepted request completes W+1 edges later unless cancelled.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 1'b0; m_done = 1'b0; m_hi = '0; m_lo = '0; m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                if (clr) begin
                    m_busy = 1'b0;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_busy = 1'b0; m_done = 1'b1; m_hi = p_hi; m_lo = p_lo;
                    end
                end
            end else if (start && !clr) begin
                if (op <= 3'd3) begin
                    calc(op, a, b, p_hi, p_lo);
                    m_busy = 1'b1;
                    m_left = W + 1;
                end else if (op == 3'd4) begin
                    m_hi = a;
                end else if (op == 3'd5) begin
                    m_lo = a;
                end
            end
        end
    end

    always @(negedge clk) begin
        n_tests++;
        if ({busy, done, hi, lo} !== {m_busy, m_done, m_hi, m_lo}) begin
            n_fail++;
            $display("FAIL cycle t=%0t busy=%b/%b done=%b/%b hi=%h/%h lo=%h/%h (got/exp)",
                     $time, busy, m_busy, done, m_done, hi, m_hi, lo, m_lo);
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic run(input logic [2:0] xop, input logic [31:0] xa, input logic [31:0] xb,
                       output int lat, output int bcnt);
        start = 1'b1; op = xop; a = xa; b = xb;
        @(negedge clk);
        start = 1'b0;
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
        end
        if (!done) chk("done_timeout", 64'(lat), 64'(W + 1));
    endtask

    task automatic issue(input logic [2:0] xop, input logic [31:0] xa);
        start = 1'b1; op = xop; a = xa;
        @(negedge clk);
        start = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom % 16);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int lat, bcnt, saw_done;
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", {busy, done, hi, lo}, '0);

        // Start on the first edge after reset release.
        reset = 1'b0;
        run(3'd0, 32'hFFFF_FFFD, 32'd5, lat, bcnt);
        chk("mult_latency", 64'(lat), 64'd33);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFF1);

        run(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
        chk("multu_busy_cycles", 64'(bcnt), 64'd33);
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);

        run(3'd2, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
        chk("div_neg_lo", lo, 32'hFFFF_FFFD);
        chk("div_neg_hi", hi, 32'hFFFF_FFFF);

        run(3'd3, 32'd7, 32'd2, lat, bcnt);
        chk("divu_lo", lo, 32'd3);
        chk("divu_hi", hi, 32'd1);

        run(3'd3, 32'd5, 32'd0, lat, bcnt);
        chk("divz_latency", 64'(lat), 64'd33);
        chk("divz_hi", hi, 32'd5);
        chk("divz_lo", lo, 32'hFFFF_FFFF);

        run(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
        chk("div_ovf_lo", lo, 32'h8000_0000);
        chk("div_ovf_hi", hi, 32'h0);

        issue(3'd4, 32'h1234_5678);
        issue(3'd5, 32'h1234_5678);
        chk("mthi_idle", hi, 32'h1234_5678);
        chk("mtlo_idle", lo, 32'h1234_5678);

        // Cancel so that clr is sampled on the 10th iteration edge.
        start = 1'b1; op = 3'd0; a = 32'd2; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_busy_low", 64'(busy), 64'd0);
        saw_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        chk("clr_no_done", 64'(saw_done), 64'd0);
        chk("clr_hi_kept", hi, 32'h1234_5678);
        chk("clr_lo_kept", lo, 32'h1234_5678);

        start = 1'b1; clr = 1'b1; op = 3'd1; a = 32'd9; b = 32'd9;
        @(negedge clk);
        start = 1'b0; clr = 1'b0;
        chk("clr_beats_start", 64'(busy), 64'd0);

        issue(3'd6, 32'hDEAD_BEEF);
        chk("reserved_op_hi", hi, 32'h1234_5678);

        // MTHI while busy must be dropped; a/b changes mid-run must not matter.
        start = 1'b1; op = 3'd0; a = 32'd2; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        issue(3'd4, 32'hDEAD_0000);
        b = 32'd1000;
        lat = 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("mthi_busy_hi", hi, 32'h0);
        chk("mthi_busy_lo", lo, 32'd6);

        issue(3'd5, 32'hCAFE_BABE);
        chk("mtlo_next_cycle", lo, 32'hCAFE_BABE);

        // Asynchronous reset in the middle of a divide.
        start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk("async_reset", {busy, done, hi, lo}, '0);
        @(negedge clk);
        reset = 1'b0;
        run(3'd3, 32'd7, 32'd2, lat, bcnt);
        chk("post_reset_latency", 64'(lat), 64'd33);
        chk("post_reset_lo", lo, 32'd3);

        repeat (3000) begin
            @(negedge clk);
            start = ($urandom % 4) == 0;
            op    = 3'($urandom % 8);
            a     = pick();
            b     = pick();
            clr   = ($urandom % 50) == 0;
        end
        @(negedge clk);
        start = 1'b0; clr = 1'b0;
        repeat (40) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 W, 32, operand and result width in bits; legal range 8 to 64, even values only.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; forces the reset state immediately, independent of clk.
REQ-004 start  in  1  single-cycle request; sampled only in IDLE.
REQ-005 op  in  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved, no effect.
REQ-006 a  in  W  operand A (multiplicand / dividend / MTHI-MTLO source).
REQ-007 b  in  W  operand B (multiplier / divisor).
REQ-008 clr  in  1  synchronous cancel (exception/eret flush).
REQ-009 busy  out  1  high while an operation is in progress (RUN or FIX).
REQ-010 done  out  1  one-cycle pulse when HI/LO have been updated by MULT/DIV.
REQ-011 hi  out  W  HI register.
REQ-012 lo  out  W  LO register.

Function
REQ-013 FSM states: IDLE, RUN, FIX.
REQ-014 IDLE + start + op in {MULT, MULTU, DIV, DIVU}: latch a, b and op; load counter = W; go to RUN; busy = 1 from the next cycle.
REQ-015 IDLE + start + MTHI/MTLO: write a to hi/lo at that edge; remain in IDLE; no busy, no done.
REQ-016 RUN: one iteration per cycle; counter decrements; after W iterations go to FIX.
- multiply: shift-add, 1 bit per cycle
- divide: restoring, 1 quotient bit per cycle
REQ-017 FIX (one cycle): apply sign correction, write hi/lo, pulse done, go to IDLE; busy = 0 in the cycle done is high.
REQ-018 Latency: start sampled at edge k; hi/lo valid and done = 1 after edge k+W+1; new start is accepted at edge k+W+2 or later.
REQ-019 Signed operations iterate on magnitudes; the 2W-bit MULT product is negated iff operand signs differ.
REQ-020 DIV sign rules: quotient negated iff signs differ; remainder takes the sign of the dividend.
REQ-021 Multiply result: hi = product[2W-1:W], lo = product[W-1:0].
REQ-022 Divide result: lo = quotient, hi = remainder.
REQ-023 Divide by zero (DIV or DIVU): hi = a, lo = all ones; the operation still takes full latency.
REQ-024 DIV of most-negative by -1: lo = most-negative (wraps), hi = 0.
REQ-025 Requests arriving while busy (start, any op including MTHI/MTLO) are ignored; no queuing.
REQ-026 clr in RUN or FIX: return to IDLE at that edge; hi/lo unchanged; no done; busy = 0 next cycle.
REQ-027 clr in IDLE has no effect.
REQ-028 clr and start in the same IDLE cycle: clr wins and the start is dropped.
REQ-029 Reserved op codes with start: no state change.
REQ-030 Operands are latched at start; a and b may change during RUN without affecting the result.

Reset
REQ-031 reset forces state = IDLE, counter = 0, hi = 0, lo = 0, busy = 0, done = 0, and clears all internal operand and accumulator registers.
REQ-032 reset mid-operation aborts it; no done pulse is produced and hi/lo read 0.
REQ-033 The first start is accepted at the first rising edge after reset deasserts.

Verification (W=32)
REQ-034 MULT, a=0xFFFFFFFD (-3), b=5 -> done at edge k+33; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-035 MULTU, a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
REQ-036 DIV, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU, a=7, b=2 -> lo=3, hi=1.
REQ-037 DIVU, a=5, b=0 -> hi=5, lo=0xFFFFFFFF.
- DIV, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-038 Cancel and ignore cases, preloaded hi=lo=0x12345678:
- MULT started, clr at iteration 10 -> no done, hi/lo unchanged.
- MTHI issued while busy -> ignored.
- MTLO issued in IDLE -> lo=a next cycle.
REQ-039 Reset cases:
- reset asserted asynchronously mid-DIV -> busy/done/hi/lo = 0 immediately.
- start at the first edge after deassert -> accepted.
